// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between NUM_REQ requesters.
// Handles one transaction at a time and returns the controller completion to the granted port.
//
// state | meaning
// IDLE  | waiting for mem_rdy and a requester; picks the next port after the last one served
// ISSUE | one-cycle mem_r_en/mem_w_en strobe with the registered address/data
// WAIT  | holding address/data until mem_cplt or timeout
// GAP   | one idle cycle so the finished requester can drop its enable
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_in,
  input  logic [NUM_REQ-1:0]             req_r_en,
  input  logic [NUM_REQ-1:0]             req_w_en,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             req_cplt,
  output logic [DATA_WIDTH-1:0]          req_data_out,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_data_in,
  output logic                           mem_r_en,
  output logic                           mem_w_en,
  input  logic                           mem_rdy,
  input  logic                           mem_cplt,
  input  logic [DATA_WIDTH-1:0]          mem_data_out,
  output logic [1:0]                     grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  // A disabled timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              grant_q, last_q, pick;
  logic [ADDR_WIDTH-1:0]   addr_q, pick_addr;
  logic [DATA_WIDTH-1:0]   data_q, pick_data;
  logic                    op_w_q, pick_w;
  logic [TW-1:0]           tmo_cnt_q;
  logic                    tmo_err_q;
  logic [NUM_REQ-1:0]      req_any;
  logic                    found, start, wait_tmo, done;
  int                      idx;

  // Scan starting one past the last served port so a persistent requester cannot win twice in a row.
  always_comb begin
    req_any = req_r_en | req_w_en;
    found   = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_any[idx]) begin
        found = 1'b1;
        pick  = 2'(idx);
      end
    end
    pick_addr = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
    pick_data = req_data_in[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
    pick_w    = req_w_en[pick];
  end

  assign start    = (state_q == IDLE) && mem_rdy && found;
  assign wait_tmo = (TIMEOUT_CYCLES > 0) && (tmo_cnt_q == TMO_LIMIT);
  assign done     = (state_q == WAIT) && (mem_cplt || wait_tmo);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req_rdy  = '0;
    req_cplt = '0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = {NUM_REQ{mem_rdy}};
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        mem_r_en = ~op_w_q;
        mem_w_en = op_w_q;
        busy     = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (done) begin
          req_cplt = NUM_REQ'(1) << grant_q;
          state_d  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q   <= '0;
      last_q    <= 2'(NUM_REQ - 1);
      addr_q    <= '0;
      data_q    <= '0;
      op_w_q    <= 1'b0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (start) begin
        grant_q <= pick;
        addr_q  <= pick_addr;
        data_q  <= pick_data;
        op_w_q  <= pick_w;
      end
      if (state_q == ISSUE) tmo_cnt_q <= '0;
      else if (state_q == WAIT && !done && tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (done) begin
        last_q <= grant_q;
        // A completion arriving in the same cycle as the limit counts as success.
        if (!mem_cplt) tmo_err_q <= 1'b1;
      end
    end
  end

  assign req_data_out = mem_data_out;
  assign mem_addr     = addr_q;
  assign mem_data_in  = data_q;
  assign grant_id     = grant_q;
  assign timeout_err  = tmo_err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter that shares the single SDRAM memory controller port between NUM_REQ requesters. Typical requesters are the CPU, system init/UART loader, and a future DMA or debug port. It replaces the static cpu_enable mux in top. It sequences one transaction at a time through the controller's rdy/r_en/w_en/cplt handshake and routes the completion back to the granted requester.

Parameters:
ADDR_WIDTH, 24, memory word address width
DATA_WIDTH, 16, memory data width
NUM_REQ, 3, number of requesters (2..4)
TIMEOUT_CYCLES, 4096, max WAIT cycles before forced release (0 = disabled)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data_in  input  NUM_REQ*DATA_WIDTH  per-requester write data
req_r_en  input  NUM_REQ  per-requester read request (level)
req_w_en  input  NUM_REQ  per-requester write request (level)
req_rdy  output  NUM_REQ  arbiter able to accept a new request
req_cplt  output  NUM_REQ  one-cycle completion pulse to the granted requester
req_data_out  output  DATA_WIDTH  read data, shared and valid while req_cplt[i] is high
mem_addr  output  ADDR_WIDTH  to controller
mem_data_in  output  DATA_WIDTH  to controller
mem_r_en  output  1  to controller
mem_w_en  output  1  to controller
mem_rdy  input  1  controller idle and accepting
mem_cplt  input  1  controller completion pulse
mem_data_out  input  DATA_WIDTH  controller read data
grant_id  output  2  index of the current/last granted requester
busy  output  1  transaction in flight (ISSUE/WAIT)
timeout_err  output  1  sticky; set when a transaction times out

Behaviour:
- Clocking and reset: one clock, synchronous active-low reset rst_n. Reset applies from any state, including mid-transaction.
- Reset values: state=IDLE; mem_r_en=mem_w_en=0; mem_addr=0; mem_data_in=0; req_cplt=0; grant_id=0; busy=0; timeout_err=0. The round-robin pointer is set to last=NUM_REQ-1, so port 0 wins first.
- Requester contract:
  - Assert r_en or w_en and hold addr/data stable until req_cplt[i].
  - Deassert en the cycle after req_cplt[i].
  - If r_en and w_en are both high, the transaction is a write.
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - req_rdy[i]=mem_rdy for all i; otherwise req_rdy=0.
  - If mem_rdy and any en is high, pick the first requesting port scanning last+1, last+2, ... (mod NUM_REQ).
  - Register grant_id, addr, data and op; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_r_en or mem_w_en=1 with the registered addr/data.
  - busy=1; clear the timeout counter; go to WAIT.
- WAIT:
  - Enables low; mem_addr/mem_data_in held.
  - On mem_cplt: req_cplt[grant_id]=1 combinationally in the same cycle; req_data_out=mem_data_out (pass-through); last=grant_id; go to GAP.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with no mem_cplt: set timeout_err, pulse req_cplt[grant_id] (data undefined), update last, go to GAP.
- GAP (1 cycle): requests are ignored so the finished requester can drop its en; busy=0; go to IDLE.
- Latency:
  - Request seen in IDLE -> controller enable: 1 cycle.
  - mem_cplt -> req_cplt: 0 cycles.
  - Minimum spacing between two issues: controller latency + 2 cycles.
- Fairness: a requester that keeps requesting cannot be granted twice in a row while another port is requesting.
- Other rules:
  - mem_cplt outside WAIT is ignored.
  - Requests that change while not granted are ignored until IDLE.
  - timeout_err clears only on reset.
  - The timeout counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and saturates.

Test Plan:
- Reset, then port 0 read of addr 0x000010 with the controller returning 0xBEEF after 6 cycles -> mem_r_en high exactly 1 cycle with mem_addr=0x000010; req_cplt[0] pulses in the same cycle as mem_cplt; req_data_out=0xBEEF.
- Ports 0, 1, 2 all request continuously -> grant order 0,1,2,0,1,2; no port is granted twice consecutively.
- Port 1 asserts r_en and w_en together with addr 0x123456 and data 0xA5A5 -> mem_w_en=1, mem_r_en=0, mem_data_in=0xA5A5.
- mem_rdy held low while port 2 requests -> req_rdy=0 and no enable; when mem_rdy rises, ISSUE follows on the next cycle.
- TIMEOUT_CYCLES=8 and the controller never completes -> timeout_err=1 and req_cplt[grant] pulse after 8 WAIT cycles; arbiter returns to IDLE and serves the next port.
- rst_n=0 during WAIT -> next cycle all outputs are at reset values; a later mem_cplt produces no req_cplt; the next grant goes to port 0.
